// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: one access at a time over a req/gnt/rvalid bus,
// returning the aligned, extended load data or an exception code to write-back.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_store,
  input  logic [1:0]  in_size,
  input  logic        in_sign_ext,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_mem_data,
  output logic [1:0]  out_exc
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        sext_q, sext_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  exc_q, exc_d;

  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic        timeout_hit;

  always_comb begin
    be_in    = 4'b1111;
    wdata_in = in_store_data;
    case (in_size)
      2'd0: begin
        be_in    = 4'b0001 << in_addr[1:0];
        wdata_in = {4{in_store_data[7:0]}};
      end
      2'd1: begin
        be_in    = in_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{in_store_data[15:0]}};
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = in_store_data;
      end
    endcase
    misaligned = ((in_size == 2'd1) && in_addr[0]) || (in_size[1] && (in_addr[1:0] != 2'b00));
  end

  always_comb begin
    byte_sel = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    load_ext = {{24{sext_q & byte_sel[7]}}, byte_sel};
      2'd1:    load_ext = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  // Counter value is the number of REQ/WAIT cycles already spent before this one.
  assign timeout_hit = ({1'b0, cnt_q} + 17'd1) >= 17'(TIMEOUT_CYCLES);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    sext_d  = sext_q;
    size_d  = size_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    exc_d   = exc_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          we_d    = in_is_store;
          sext_d  = in_sign_ext;
          size_d  = in_size;
          addr_d  = in_addr;
          be_d    = be_in;
          wdata_d = wdata_in;
          data_d  = '0;
          cnt_d   = '0;
          if (misaligned) begin
            exc_d   = in_is_store ? 2'd2 : 2'd1;
            state_d = StDone;
          end else begin
            exc_d   = 2'd0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_gnt) begin
          state_d = StWait;
        end else if (timeout_hit) begin
          exc_d   = 2'd3;
          data_d  = '0;
          state_d = StDone;
        end
      end
      StWait: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid) begin
          exc_d   = 2'd0;
          data_d  = we_q ? 32'd0 : load_ext;
          state_d = StDone;
        end else if (timeout_hit) begin
          exc_d   = 2'd3;
          data_d  = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      exc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
    end
  end

  assign in_ready     = (state_q == StIdle) && !reset;
  assign mem_req      = (state_q == StReq);
  assign mem_we       = mem_req & we_q;
  assign mem_addr     = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_be       = mem_req ? be_q : 4'd0;
  assign mem_wdata    = mem_req ? wdata_q : 32'd0;
  assign out_valid    = (state_q == StDone);
  assign out_mem_data = out_valid ? data_q : 32'd0;
  assign out_exc      = out_valid ? exc_q : 2'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a byte-lane reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_is_store = 1'b0;
  logic [1:0]  in_size = 2'd0;
  logic        in_sign_ext = 1'b0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_store_data = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_mem_data;
  logic [1:0]  out_exc;

  int checks = 0;
  int failures = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_is_store(in_is_store), .in_size(in_size), .in_sign_ext(in_sign_ext),
    .in_addr(in_addr), .in_store_data(in_store_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_mem_data(out_mem_data), .out_exc(out_exc)
  );

  always #5 clk = ~clk;

  // One complete access. g/r = idle cycles before gnt/rvalid, h = cycles of out_ready=0.
  task automatic do_access(input bit st, input bit [1:0] sz, input bit sx,
                           input bit [31:0] ad, input bit [31:0] sd, input bit [31:0] rd,
                           input int g, input int r, input int h, input string nm);
    int n, a;
    bit mis;
    bit [3:0] ebe;
    bit [31:0] ewd, edata, eaddr;
    bit [1:0] eexc;
    longint v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    a = int'(ad[1:0]);
    mis = (a % n) != 0;
    eaddr = ad & 32'hFFFF_FFFC;
    ebe = '0;
    ewd = '0;
    for (int i = 0; i < 4; i++) begin
      ebe[i] = (i >= a) && (i < a + n);
      ewd[8*i +: 8] = sd[8*(i % n) +: 8];
    end
    v = longint'(rd) >> (8 * a);
    v = v & ((64'd1 << (8 * n)) - 1);
    if (sx && n < 4 && v[8*n-1]) v = v - (64'd1 << (8 * n));
    edata = st ? 32'd0 : v[31:0];
    eexc = mis ? (st ? 2'd2 : 2'd1) : 2'd0;
    if (mis) edata = 32'd0;

    @(negedge clk);
    in_valid = 1'b1; in_is_store = st; in_size = sz; in_sign_ext = sx;
    in_addr = ad; in_store_data = sd;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL %s accept: in_ready=%b exp 1", nm, in_ready);
    end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_addr = $urandom; in_store_data = $urandom; in_size = 2'($urandom);
    if (!mis) begin
      for (int k = 0; k <= g; k++) begin
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_be, out_valid} !== {1'b1, st, eaddr, ebe, 1'b0}) begin
          failures++;
          $display("FAIL %s req: req=%b we=%b addr=%h be=%b ov=%b exp 1 %b %h %b 0",
                   nm, mem_req, mem_we, mem_addr, mem_be, out_valid, st, eaddr, ebe);
        end
        if (st) begin
          checks++;
          if (mem_wdata !== ewd) begin
            failures++; $display("FAIL %s wdata: got %h exp %h", nm, mem_wdata, ewd);
          end
        end
        mem_gnt = (k == g);
        mem_rvalid = 1'b1;  // not sampled outside WAIT
        mem_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
      end
      for (int k = 0; k <= r; k++) begin
        checks++;
        if ({mem_req, out_valid} !== 2'b00) begin
          failures++; $display("FAIL %s wait: req=%b ov=%b exp 0 0", nm, mem_req, out_valid);
        end
        mem_rvalid = (k == r);
        mem_rdata = (k == r) ? rd : $urandom;
        @(posedge clk); @(negedge clk);
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
    for (int k = 0; k <= h; k++) begin
      checks++;
      if ({out_valid, out_mem_data, out_exc, in_ready, mem_req} !== {1'b1, edata, eexc, 2'b00})
      begin
        failures++;
        $display("FAIL %s done: ov=%b data=%h exc=%0d ir=%b req=%b exp 1 %h %0d 0 0",
                 nm, out_valid, out_mem_data, out_exc, in_ready, mem_req, edata, eexc);
      end
      in_valid = (k < h);
      out_ready = (k == h);
      @(posedge clk); @(negedge clk);
    end
    out_ready = 1'b0; in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL %s release: ov=%b ir=%b exp 0 1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, out_valid, out_mem_data,
         out_exc} !== '0) begin
      failures++; $display("FAIL reset_outputs: some output nonzero during reset, exp all 0");
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, mem_req} !== 3'b100) begin
      failures++;
      $display("FAIL reset_release: ir=%b ov=%b req=%b exp 1 0 0", in_ready, out_valid, mem_req);
    end
  endtask

  task automatic test_directed();
    do_access(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h8011_2233, 0, 0, 0, "lb_sext");
    do_access(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h8011_2233, 0, 0, 0, "lb_zext");
    do_access(1'b1, 2'd1, 1'b0, 32'h2002, 32'hDEAD_BEEF, 32'h1234_5678, 1, 1, 0, "sh");
    do_access(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 0, 0, 0, "lw_misaligned");
    do_access(1'b1, 2'd2, 1'b0, 32'h3002, 32'h5555_AAAA, 32'h0, 0, 0, 0, "sw_misaligned");
    do_access(1'b0, 2'd1, 1'b1, 32'h4002, 32'h0, 32'h9ABC_1234, 0, 1, 5, "lh_backpressure");
  endtask

  task automatic test_timeout();
    @(negedge clk);
    in_valid = 1'b1; in_is_store = 1'b0; in_size = 2'd2; in_addr = 32'h7000;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({mem_req, out_valid} !== 2'b10) begin
        failures++; $display("FAIL timeout_req%0d: req=%b ov=%b exp 1 0", k, mem_req, out_valid);
      end
      @(posedge clk); @(negedge clk);
    end
    checks++;
    if ({out_valid, out_exc, out_mem_data, mem_req} !== {1'b1, 2'd3, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL timeout_done: ov=%b exc=%0d data=%h exp 1 3 0", out_valid, out_exc,
               out_mem_data);
    end
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    checks++;
    if ({out_valid, out_exc, out_mem_data, mem_req} !== {1'b1, 2'd3, 32'd0, 1'b0}) begin
      failures++;
      $display("FAIL timeout_stray: ov=%b exc=%0d data=%h exp 1 3 0", out_valid, out_exc,
               out_mem_data);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL timeout_release: ov=%b ir=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    int nv, nr, ni, bad;
    nv = 0; nr = 0; ni = 0; bad = 0;
    @(negedge clk);
    in_valid = 1'b1; in_is_store = 1'b0; in_size = 2'd2; in_addr = 32'h40;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; out_ready = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) begin
        nv++;
        if (out_mem_data !== 32'hCAFE_F00D) bad++;
      end
      if (mem_req) nr++;
      if (in_ready) ni++;
    end
    in_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; out_ready = 1'b0;
    checks++;
    if ({nv, nr, ni, bad} !== {32'd3, 32'd3, 32'd3, 32'd0}) begin
      failures++;
      $display("FAIL back_to_back: valid=%0d req=%0d ready=%0d baddata=%0d exp 3 3 3 0",
               nv, nr, ni, bad);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_valid = 1'b1; in_is_store = 1'b1; in_size = 2'd2; in_addr = 32'h500;
    in_store_data = 32'h1111_2222;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; mem_gnt = 1'b1;
    @(posedge clk); @(negedge clk);
    mem_gnt = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata, out_valid, out_mem_data,
         out_exc} !== '0) begin
      failures++; $display("FAIL reset_mid: ir=%b req=%b ov=%b exp all 0", in_ready, mem_req,
                           out_valid);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      failures++; $display("FAIL reset_mid_release: ir=%b ov=%b exp 1 0", in_ready, out_valid);
    end
    @(posedge clk); @(negedge clk);
    mem_rvalid = 1'b0;
    checks++;
    if ({in_ready, out_valid, mem_req} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_late_rvalid: ir=%b ov=%b req=%b exp 1 0 0", in_ready, out_valid,
               mem_req);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 2)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
